// File: rtl/acc_bank.sv
// acc_bank: NUM_ACC accumulators fed from BUS through a shared ALU, with global Z/N/C/V flags.
// Define ACC_MUL_EN to build in the multi-cycle shift-add multiplier for opcode 11.
module acc_bank #(
    parameter int WIDTH   = 8,
    parameter int NUM_ACC = 4,
    localparam int SW     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] BUS,
    input  logic [SW-1:0]    ACC_SEL,
    input  logic [3:0]       OP,
    input  logic             OP_VALID,
    input  logic             Z_LOAD,
    input  logic             AC_BUS,
    output logic [WIDTH-1:0] AC_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_CLR  = 4'd10;
    localparam logic [SW:0] NUM_ACC_L = (SW+1)'(NUM_ACC);

    logic [WIDTH-1:0] acc_val [NUM_ACC];
    logic             z_reg, n_reg, c_reg, v_reg, done_reg;
    logic             busy;
    logic             accept;
    logic             sel_ok;
    logic [WIDTH-1:0] sel_val;

    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_wr;
    logic             single_wr;

    logic             wr_en;
    logic [SW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_val;
    logic             fl_en;
    logic             c_next, v_next;

    // Out-of-range selects (non power-of-two NUM_ACC) read as zero and never write.
    assign sel_ok  = ({1'b0, ACC_SEL} < NUM_ACC_L);
    assign sel_val = sel_ok ? acc_val[ACC_SEL] : '0;
    assign accept  = OP_VALID && !busy;

    assign sum_ext  = {1'b0, sel_val} + {1'b0, BUS};
    assign diff_ext = {1'b0, sel_val} - {1'b0, BUS};

    always_comb begin
        alu_res = sel_val;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        case (OP)
            OP_LOAD: alu_res = BUS;
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (sel_val[WIDTH-1] == BUS[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != sel_val[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (sel_val[WIDTH-1] != BUS[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != sel_val[WIDTH-1]);
            end
            OP_AND: alu_res = sel_val & BUS;
            OP_OR:  alu_res = sel_val | BUS;
            OP_XOR: alu_res = sel_val ^ BUS;
            OP_NOT: alu_res = ~sel_val;
            OP_SHL: begin
                alu_res = {sel_val[WIDTH-2:0], 1'b0};
                alu_c   = sel_val[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, sel_val[WIDTH-1:1]};
                alu_c   = sel_val[0];
            end
            OP_CLR: alu_res = '0;
            default: alu_wr = 1'b0;
        endcase
    end

    assign single_wr = accept && alu_wr && sel_ok;

`ifdef ACC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t             state_reg;
    logic [SW-1:0]      tgt_reg;
    logic [2*WIDTH-1:0] mcand_reg, prod_reg, prod_next;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;
    logic               zl_reg;
    logic               mul_start, mul_fin;

    assign busy      = (state_reg == ST_MUL);
    assign mul_start = accept && sel_ok && (OP == OP_MUL);
    assign mul_fin   = busy && (cnt_reg == CW'(1));
    assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg  <= ST_IDLE;
            tgt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            zl_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mul_start) begin
                        state_reg  <= ST_MUL;
                        tgt_reg    <= ACC_SEL;
                        mcand_reg  <= {{WIDTH{1'b0}}, sel_val};
                        mplier_reg <= BUS;
                        prod_reg   <= '0;
                        cnt_reg    <= CW'(WIDTH);
                        zl_reg     <= Z_LOAD;
                    end
                end
                ST_MUL: begin
                    prod_reg   <= prod_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1))
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
`else
    assign busy = 1'b0;
`endif

    // The last multiply step writes prod_next directly, so the result lands on the final MUL edge.
    always_comb begin
        wr_en  = single_wr;
        wr_idx = ACC_SEL;
        wr_val = alu_res;
        fl_en  = single_wr && Z_LOAD;
        c_next = alu_c;
        v_next = alu_v;
`ifdef ACC_MUL_EN
        if (mul_fin) begin
            wr_en  = 1'b1;
            wr_idx = tgt_reg;
            wr_val = prod_next[WIDTH-1:0];
            fl_en  = zl_reg;
            c_next = |prod_next[2*WIDTH-1:WIDTH];
            v_next = |prod_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ACC; gi++) begin : g_acc
            logic [WIDTH-1:0] val_reg;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N)
                    val_reg <= '0;
                else if (wr_en && (wr_idx == SW'(gi)))
                    val_reg <= wr_val;
            end
            assign acc_val[gi] = val_reg;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            z_reg    <= 1'b0;
            n_reg    <= 1'b0;
            c_reg    <= 1'b0;
            v_reg    <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= wr_en;
            if (fl_en) begin
                z_reg <= (wr_val == '0);
                n_reg <= wr_val[WIDTH-1];
                c_reg <= c_next;
                v_reg <= v_next;
            end
        end
    end

    assign AC_OUT = AC_BUS ? sel_val : {WIDTH{1'bz}};
    assign BUSY   = busy;
    assign DONE   = done_reg;
    assign Z      = z_reg;
    assign N      = n_reg;
    assign C      = c_reg;
    assign V      = v_reg;

endmodule
